// File: rtl/bounce_generator.sv
// bounce_generator: mechanical-contact emulator. A change on the commanded
// level becomes a burst of toggles with LFSR-chosen gaps, then the final level
// is held for a fixed settle time and completion is pulsed. Every output is a
// flop; i_level only reaches the outputs through registered state.
module bounce_generator #(
  parameter int          BOUNCE_COUNT  = 3,
  parameter int          MIN_GAP       = 4,
  parameter int          GAP_BITS      = 4,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_bounce,
  output logic o_busy,
  output logic o_settled
);

  localparam int GAP_W    = $clog2(MIN_GAP + 2**GAP_BITS + 1);
  localparam int EDGE_MAX = 2 * BOUNCE_COUNT;
  // Keep the edge counter at least one bit wide when no bounces are requested.
  localparam int EDGE_W   = (EDGE_MAX > 0) ? $clog2(EDGE_MAX + 1) : 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
  localparam logic [15:0]         SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]         LFSR_TAPS   = 16'hB400;
  localparam logic [GAP_W-1:0]    MIN_GAP_W   = GAP_W'(MIN_GAP);
  localparam logic [EDGE_W-1:0]   EDGE_INIT   = EDGE_W'(EDGE_MAX);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUNCE,
    ST_SETTLE
  } state_t;

  state_t              state_q,   state_d;
  logic                target_q,  target_d;
  logic                bounce_q,  bounce_d;
  logic                busy_q,    busy_d;
  logic                settled_q, settled_d;
  logic [GAP_W-1:0]    gap_q,     gap_d;
  logic [EDGE_W-1:0]   edges_q,   edges_d;
  logic [SETTLE_W-1:0] settle_q,  settle_d;
  logic [15:0]         lfsr_q,    lfsr_d;

  logic [15:0]         lfsr_step;
  logic [GAP_W-1:0]    gap_load;

  // LFSR successor and the gap it would produce; both are consumed only when a
  // gap is actually loaded, so the LFSR advances exactly once per output edge.
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    gap_load  = MIN_GAP_W + GAP_W'(lfsr_q[GAP_BITS-1:0]);
  end

  // Next-state and output logic for the idle / bounce / settle sequencer.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    bounce_d  = bounce_q;
    busy_d    = busy_q;
    settled_d = 1'b0;
    gap_d     = gap_q;
    edges_d   = edges_q;
    settle_d  = settle_q;
    lfsr_d    = lfsr_q;

    case (state_q)
      ST_IDLE: begin
        // i_level is only looked at here, so changes while busy are ignored.
        if (i_level != target_q) begin
          target_d = i_level;
          bounce_d = i_level;
          gap_d    = gap_load;
          lfsr_d   = lfsr_step;
          edges_d  = EDGE_INIT;
          busy_d   = 1'b1;
          if (BOUNCE_COUNT == 0) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_INIT;
          end else begin
            state_d = ST_BOUNCE;
          end
        end
      end

      ST_BOUNCE: begin
        if (gap_q <= GAP_W'(1)) begin
          bounce_d = ~bounce_q;
          edges_d  = edges_q - EDGE_W'(1);
          gap_d    = gap_load;
          lfsr_d   = lfsr_step;
          // Even number of toggles after the first edge: this one lands on target.
          if (edges_q == EDGE_W'(1)) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_INIT;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      ST_SETTLE: begin
        if (settle_q <= SETTLE_W'(1)) begin
          settled_d = 1'b1;
          busy_d    = 1'b0;
          settle_d  = '0;
          state_d   = ST_IDLE;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      target_q  <= 1'b0;
      bounce_q  <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
      gap_q     <= '0;
      edges_q   <= '0;
      settle_q  <= '0;
      lfsr_q    <= SEED_EFF;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      bounce_q  <= bounce_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
      gap_q     <= gap_d;
      edges_q   <= edges_d;
      settle_q  <= settle_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign o_bounce  = bounce_q;
  assign o_busy    = busy_q;
  assign o_settled = settled_q;

endmodule

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator: directed checks of bounce_generator against a small
// reference LFSR model. Instance 0: BOUNCE_COUNT=2, instance 1: BOUNCE_COUNT=0,
// instance 2: SEED=0 (expected to behave as SEED=1).
`timescale 1ns/1ps
module tb_bounce_generator;

  localparam int MG = 3;
  localparam int SC = 10;

  logic clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] lvl;
  logic [2:0] bnc;
  logic [2:0] bsy;
  logic [2:0] stl;

  logic [15:0] mlfsr [3];
  logic [2:0]  mtgt;
  int          bcnt  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bounce_generator #(.BOUNCE_COUNT(2), .MIN_GAP(MG), .GAP_BITS(2),
                     .SETTLE_CYCLES(SC), .SEED(16'hACE1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_level(lvl[0]),
    .o_bounce(bnc[0]), .o_busy(bsy[0]), .o_settled(stl[0]));

  bounce_generator #(.BOUNCE_COUNT(0), .MIN_GAP(MG), .GAP_BITS(2),
                     .SETTLE_CYCLES(SC), .SEED(16'hACE1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_level(lvl[1]),
    .o_bounce(bnc[1]), .o_busy(bsy[1]), .o_settled(stl[1]));

  bounce_generator #(.BOUNCE_COUNT(2), .MIN_GAP(MG), .GAP_BITS(2),
                     .SETTLE_CYCLES(SC), .SEED(16'h0000)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_level(lvl[2]),
    .o_bounce(bnc[2]), .o_busy(bsy[2]), .o_settled(stl[2]));

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input int k, input string tag,
                     input logic eb, input logic ey, input logic es);
    n_checks++;
    assert ({bnc[k], bsy[k], stl[k]} === {eb, ey, es})
      else begin
        n_fail++;
        $error("FAIL %s inst%0d t=%0t: bounce/busy/settled observed %b%b%b expected %b%b%b",
               tag, k, $time, bnc[k], bsy[k], stl[k], eb, ey, es);
      end
  endtask

  // Runs one full sequence on instance k toward newlvl, checking every cycle.
  // start=1 drives the level change; start=0 means the change is already
  // pending. mode 1 glitches the level away and back while busy; mode 2 moves
  // it away and leaves it, so the caller must continue with a new sequence.
  task automatic run_seq(input int k, input logic newlvl, input bit start, input int mode);
    int   g;
    logic expb;
    if (start) lvl[k] = newlvl;
    @(negedge clk);
    expb = newlvl;
    chk(k, "edge1", expb, 1'b1, 1'b0);
    g = MG + int'(mlfsr[k][1:0]);
    mlfsr[k] = lfsr_next(mlfsr[k]);
    for (int e = 0; e < 2 * bcnt[k]; e++) begin
      for (int c = 1; c < g; c++) begin
        if (e == 0 && c == 1 && mode != 0) lvl[k] = ~newlvl;
        if (e == 0 && c == 2 && mode == 1) lvl[k] = newlvl;
        @(negedge clk);
        chk(k, "gap_hold", expb, 1'b1, 1'b0);
      end
      @(negedge clk);
      expb = ~expb;
      chk(k, "bounce_edge", expb, 1'b1, 1'b0);
      g = MG + int'(mlfsr[k][1:0]);
      mlfsr[k] = lfsr_next(mlfsr[k]);
    end
    for (int c = 1; c < SC; c++) begin
      @(negedge clk);
      chk(k, "settle_hold", newlvl, 1'b1, 1'b0);
    end
    @(negedge clk);
    chk(k, "settled_pulse", newlvl, 1'b0, 1'b1);
    mtgt[k] = newlvl;
    if (mode != 2) begin
      @(negedge clk);
      chk(k, "idle_after", newlvl, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bcnt[0] = 2; bcnt[1] = 0; bcnt[2] = 2;
    mlfsr[0] = 16'hACE1; mlfsr[1] = 16'hACE1; mlfsr[2] = 16'h0001;
    mtgt  = 3'b000;
    lvl   = 3'b000;
    rst_n = 3'b000;

    // Reset state.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk(k, "reset", 1'b0, 1'b0, 1'b0);
    rst_n = 3'b111;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk(k, "idle_post_reset", 1'b0, 1'b0, 1'b0);

    // Basic rising sequence, then a falling one.
    run_seq(0, 1'b1, 1'b1, 0);
    run_seq(0, 1'b0, 1'b1, 0);

    // Glitch 1->0->1 during busy: unaffected, and no new sequence afterwards.
    run_seq(0, 1'b1, 1'b1, 1);
    repeat (3) begin
      @(negedge clk);
      chk(0, "no_restart", 1'b1, 1'b0, 1'b0);
    end

    // Level moves away during busy: new sequence right after the settled pulse.
    run_seq(0, 1'b0, 1'b1, 2);
    run_seq(0, 1'b1, 1'b0, 0);

    // Asynchronous reset mid-sequence, released with i_level high.
    lvl[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    assert (bsy[0] === 1'b1)
      else begin
        n_fail++;
        $error("FAIL pre_reset_busy inst0: observed %b expected 1", bsy[0]);
      end
    #2 rst_n[0] = 1'b0;
    #1 chk(0, "async_reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    lvl[0] = 1'b1;
    @(negedge clk);
    chk(0, "reset_hold", 1'b0, 1'b0, 1'b0);
    mlfsr[0] = 16'hACE1;
    mtgt[0]  = 1'b0;
    rst_n[0] = 1'b1;
    run_seq(0, 1'b1, 1'b0, 0);

    // No bounces: single edge, then settle.
    run_seq(1, 1'b1, 1'b1, 0);
    run_seq(1, 1'b0, 1'b1, 0);

    // Random transitions with idle spacing and optional glitches.
    for (int i = 0; i < 200; i++) begin
      int idle_n;
      idle_n = int'($urandom_range(0, 3));
      for (int j = 0; j < idle_n; j++) begin
        @(negedge clk);
        chk(0, "rand_idle", mtgt[0], 1'b0, 1'b0);
      end
      run_seq(0, ~mtgt[0], 1'b1, int'($urandom_range(0, 1)));
    end

    // Zero seed behaves as seed 1 and never sticks.
    for (int i = 0; i < 1000; i++) begin
      run_seq(2, ~mtgt[2], 1'b1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
